// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory lane controller: RV32 load/store
// funct3 codes, controller state encoding and the store lane-mask helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  // Which byte lanes a store of the given size touches at byte offset off.
  // Halfword lanes follow off[1] only, so a masked offset and a raw offset
  // give the same answer.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   laneMask = 4'b0001 << off;
      2'b01:   laneMask = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   laneMask = 4'b1111;
      default: laneMask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bundle between the load/store unit (master) and the
// data-memory lane controller (slave).
interface dmem_lane_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              busy;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, busy, rdata, rvalid, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, busy, rdata, rvalid, err
  );

endinterface

// File: rtl/dmem_load_align.sv
// Picks the byte/halfword addressed by a load out of a 32-bit word and
// sign- or zero-extends it according to funct3. Purely combinational.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension; unknown sizes pass the word through.
  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// RV32 data memory with byte-lane stores, extended loads, registered read
// data and a post-reset clear sweep.
// Optional build macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses fault; otherwise the offset is forced to natural
// alignment and the access proceeds.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input logic clk,
  input logic rst_n,
  dmem_lane_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]       r_mem [DEPTH_WORDS];
  state_t            r_state;
  state_t            w_stateNext;
  logic [IDX_W-1:0]  r_clrCnt;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_off;
  logic              w_accept;
  logic              w_rangeFault;
  logic              w_sizeFault;
  logic              w_alignFault;
  logic              w_fault;
  logic [3:0]        w_laneMask;
  logic [31:0]       w_wdataRep;
  logic [31:0]       w_word;
  logic [31:0]       w_loadData;

  assign w_addr       = bus.addr;
  assign w_idx        = w_addr[IDX_W+1:2];
  assign w_accept     = bus.req && (r_state == RUN);
  assign w_rangeFault = (w_addr >> (IDX_W + 2)) != '0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_off        = w_addr[1:0];
  assign w_alignFault = ((bus.funct3[1:0] == 2'b01) && w_addr[0]) ||
                        ((bus.funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
  assign w_off        = (bus.funct3[1:0] == 2'b01) ? {w_addr[1], 1'b0} :
                        (bus.funct3[1:0] == 2'b10) ? 2'b00 : w_addr[1:0];
  assign w_alignFault = 1'b0;
`endif

  assign w_fault    = w_rangeFault || w_sizeFault || w_alignFault;
  assign w_laneMask = laneMask(bus.funct3[1:0], w_off);
  assign w_word     = r_mem[w_idx];

  assign bus.ready  = (r_state == RUN);
  assign bus.busy   = (r_state == CLEAR);
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;

  // Legal funct3 codes differ between stores (no unsigned forms) and loads.
  always_comb begin
    w_sizeFault = 1'b1;
    if (bus.we) w_sizeFault = !(bus.funct3 inside {F3_B, F3_H, F3_W});
    else        w_sizeFault = !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

  // Replicate store data across lanes so the lane mask alone picks the target bytes.
  always_comb begin
    w_wdataRep = bus.wdata;
    case (bus.funct3[1:0])
      2'b00:   w_wdataRep = {4{bus.wdata[7:0]}};
      2'b01:   w_wdataRep = {2{bus.wdata[15:0]}};
      default: w_wdataRep = bus.wdata;
    endcase
  end

  dmem_load_align u_align (
    .i_word   (w_word),
    .i_funct3 (bus.funct3),
    .i_off    (w_off),
    .o_data   (w_loadData)
  );

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CLEAR;
    else        r_state <= w_stateNext;
  end

  // Leave CLEAR once the last word has been zeroed.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      CLEAR:   if (r_clrCnt == IDX_W'(DEPTH_WORDS - 1)) w_stateNext = RUN;
      RUN:     w_stateNext = RUN;
      default: w_stateNext = CLEAR;
    endcase
  end

  // Clear sweep pointer, one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_clrCnt <= '0;
    else if (r_state == CLEAR) r_clrCnt <= r_clrCnt + 1'b1;
  end

  // Array writes: zero fill during CLEAR, masked lane stores in RUN.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_accept && bus.we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_laneMask[i]) r_mem[w_idx][8*i +: 8] <= w_wdataRep[8*i +: 8];
      end
    end
  end

  // Response registers: pulses for accepted accesses, rdata held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_accept && !bus.we;
      r_err    <= w_accept && w_fault;
      if (w_accept && !bus.we) r_rdata <= w_fault ? 32'h0 : w_loadData;
    end
  end

endmodule
